// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake field engine.
// Cell coordinates are carried at a fixed 8-bit width inside cell_t.
package snake_pkg;

  localparam int CMW = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    PLACE,
    GAME_OVER
  } state_t;

  localparam logic [2:0] RGB_BORDER = 3'b111;
  localparam logic [2:0] RGB_HEAD   = 3'b011;
  localparam logic [2:0] RGB_BODY   = 3'b010;
  localparam logic [2:0] RGB_FRUIT  = 3'b100;
  localparam logic [2:0] RGB_BG     = 3'b000;

  typedef struct packed {
    logic [CMW-1:0] x;
    logic [CMW-1:0] y;
  } cell_t;

  localparam cell_t HEAD0  = '{x: 8'd2, y: 8'd2};
  localparam cell_t FRUIT0 = '{x: 8'd6, y: 8'd6};

  function automatic dir_t rev(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit BCD incrementer, wraps 9999 -> 0000.
// Synchronous clear has priority over the increment enable.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] q
);

  logic [15:0] nxt;
  logic        carry;

  always_comb begin
    nxt   = q;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (q[4*d +: 4] == 4'd9) begin
          nxt[4*d +: 4] = 4'd0;
        end else begin
          nxt[4*d +: 4] = q[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/snake_field_engine.sv
// snake_field_engine: grid snake game core with registered pixel colour.
// Define SNAKE_WALL_DEATH_EN to make leaving the grid fatal instead of wrapping.
module snake_field_engine
  import snake_pkg::*;
#(
  parameter int GRID_W      = 24,
  parameter int GRID_H      = 19,
  parameter int CELL_PX     = 25,
  parameter int ORG_X       = 2,
  parameter int ORG_Y       = 2,
  parameter int MAX_LEN     = 32,
  parameter int TICK_CYCLES = 8000000,
  parameter int CW          = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                dir,
  input  logic [CW-1:0]             rand_x,
  input  logic [CW-1:0]             rand_y,
  input  logic                      video_on,
  input  logic [9:0]                pix_x,
  input  logic [9:0]                pix_y,
  output logic [2:0]                graph_rgb,
  output logic [15:0]               score,
  output logic [$clog2(MAX_LEN):0]  length,
  output logic [CW-1:0]             head_x,
  output logic [CW-1:0]             head_y,
  output logic                      fruit_eaten,
  output logic                      game_over
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
`ifdef SNAKE_WALL_DEATH_EN
  localparam bit WALL_DIE = 1'b1;
`else
  localparam bit WALL_DIE = 1'b0;
`endif
  localparam logic [CMW-1:0] XMAX = CMW'(GRID_W - 1);
  localparam logic [CMW-1:0] YMAX = CMW'(GRID_H - 1);
  localparam logic [CMW-1:0] ONE  = CMW'(1);

  state_t          state;
  logic [TW-1:0]   cnt;
  dir_t            dir_q;
  dir_t            last_dir;
  cell_t           body [MAX_LEN];
  logic [PW-1:0]   hptr;
  logic [LW-1:0]   len;
  cell_t           head;
  cell_t           fruit;
  cell_t           nh;
  cell_t           cand;
  cell_t           pcell;
  logic            pend;
  logic            tick;
  logic            wall;
  logic            hit_step;
  logic            hit_all;
  logic            die;
  logic            eat;
  logic            border;
  logic            pbody;
  logic [2:0]      rgb_n;
  logic [MAX_LEN-1:0] occ;
  logic [MAX_LEN-1:0] occ_step;
  int              px;
  int              py;

  assign tick   = cnt == TW'(TICK_CYCLES - 1);
  assign length = len;
  assign head_x = head.x[CW-1:0];
  assign head_y = head.y[CW-1:0];

  // Segment age is head_ptr-index; the tail (age len-1) is vacating.
  always_comb begin
    occ      = '0;
    occ_step = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      occ[i]      = LW'(PW'(hptr - PW'(i))) < len;
      occ_step[i] = LW'(PW'(hptr - PW'(i))) + LW'(1) < len;
    end
  end

  always_comb begin
    nh   = head;
    wall = 1'b0;
    unique case (dir_q)
      DIR_UP: begin
        wall = head.y == '0;
        nh.y = wall ? YMAX : head.y - ONE;
      end
      DIR_DOWN: begin
        wall = head.y == YMAX;
        nh.y = wall ? '0 : head.y + ONE;
      end
      DIR_LEFT: begin
        wall = head.x == '0;
        nh.x = wall ? XMAX : head.x - ONE;
      end
      DIR_RIGHT: begin
        wall = head.x == XMAX;
        nh.x = wall ? '0 : head.x + ONE;
      end
    endcase
  end

  always_comb begin
    cand.x = CMW'(rand_x);
    cand.y = CMW'(rand_y);
    if (cand.x >= CMW'(GRID_W)) cand.x = cand.x - CMW'(GRID_W);
    if (cand.y >= CMW'(GRID_H)) cand.y = cand.y - CMW'(GRID_H);
    hit_step = 1'b0;
    hit_all  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (occ_step[i] && body[i] == nh) hit_step = 1'b1;
      if (occ[i] && body[i] == cand) hit_all = 1'b1;
    end
  end

  assign die = hit_step | (WALL_DIE & wall);
  assign eat = (state == STEP) && !die && (nh == fruit);

  bcd_counter4 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (eat),
    .clr   (state == GAME_OVER && start),
    .q     (score)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend        <= 1'b0;
      dir_q       <= DIR_RIGHT;
      last_dir    <= DIR_RIGHT;
      hptr        <= '0;
      len         <= LW'(1);
      head        <= HEAD0;
      fruit       <= FRUIT0;
      fruit_eaten <= 1'b0;
      game_over   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) body[i] <= '0;
      body[0]     <= HEAD0;
    end else begin
      fruit_eaten <= 1'b0;
      if (state inside {RUN, STEP, PLACE}) begin
        cnt <= tick ? '0 : cnt + TW'(1);
      end
      if (tick && state inside {STEP, PLACE}) pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (dir_t'(dir) != rev(last_dir)) dir_q <= dir_t'(dir);
          if (tick || pend) begin
            state <= STEP;
            pend  <= 1'b0;
          end
        end
        STEP: begin
          if (die) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
          end else begin
            hptr               <= hptr + PW'(1);
            body[hptr + PW'(1)] <= nh;
            head               <= nh;
            last_dir           <= dir_q;
            if (eat) begin
              if (len != LW'(MAX_LEN)) len <= len + LW'(1);
              fruit_eaten <= 1'b1;
              state       <= PLACE;
            end else begin
              state <= RUN;
            end
          end
        end
        PLACE: begin
          if (!hit_all) begin
            fruit <= cand;
            if (pend || tick) begin
              state <= STEP;
              pend  <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        GAME_OVER: begin
          if (start) begin
            state     <= RUN;
            game_over <= 1'b0;
            cnt       <= '0;
            pend      <= 1'b0;
            dir_q     <= DIR_RIGHT;
            last_dir  <= DIR_RIGHT;
            hptr      <= '0;
            len       <= LW'(1);
            head      <= HEAD0;
            fruit     <= FRUIT0;
            for (int i = 0; i < MAX_LEN; i++) body[i] <= '0;
            body[0]   <= HEAD0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    px    = int'(pix_x);
    py    = int'(pix_y);
    pcell = '0;
    for (int c = 0; c < GRID_W; c++) begin
      if (px >= ORG_X + c * CELL_PX && px < ORG_X + (c + 1) * CELL_PX)
        pcell.x = CMW'(c);
    end
    for (int r = 0; r < GRID_H; r++) begin
      if (py >= ORG_Y + r * CELL_PX && py < ORG_Y + (r + 1) * CELL_PX)
        pcell.y = CMW'(r);
    end
    border = px < ORG_X || px >= ORG_X + GRID_W * CELL_PX ||
             py < ORG_Y || py >= ORG_Y + GRID_H * CELL_PX;
    pbody = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (occ[i] && body[i] == pcell) pbody = 1'b1;
    end
    if (!video_on)           rgb_n = RGB_BG;
    else if (border)         rgb_n = RGB_BORDER;
    else if (pcell == head)  rgb_n = RGB_HEAD;
    else if (pbody)          rgb_n = RGB_BODY;
    else if (pcell == fruit) rgb_n = RGB_FRUIT;
    else                     rgb_n = RGB_BG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) graph_rgb <= '0;
    else        graph_rgb <= rgb_n;
  end

endmodule

// File: tb/tb_snake_field_engine.sv
// tb_snake_field_engine: directed game scenarios for snake_field_engine.
// Game tick shortened to 4 cycles; expectations are hand-computed.
module tb_snake_field_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start;
  logic [1:0]  dir;
  logic [4:0]  rand_x;
  logic [4:0]  rand_y;
  logic        video_on;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [2:0]  graph_rgb;
  logic [15:0] score;
  logic [5:0]  length;
  logic [4:0]  head_x;
  logic [4:0]  head_y;
  logic        fruit_eaten;
  logic        game_over;

  int checks = 0;
  int fails = 0;
  int eat_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (fruit_eaten === 1'b1) eat_cnt++;

  snake_field_engine #(
    .TICK_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dir         (dir),
    .rand_x      (rand_x),
    .rand_y      (rand_y),
    .video_on    (video_on),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .graph_rgb   (graph_rgb),
    .score       (score),
    .length      (length),
    .head_x      (head_x),
    .head_y      (head_y),
    .fruit_eaten (fruit_eaten),
    .game_over   (game_over)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_wait(output int n);
    logic [4:0] ox;
    logic [4:0] oy;
    logic       og;
    ox = head_x;
    oy = head_y;
    og = game_over;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (head_x == ox && head_y == oy && game_over == og && n < 16);
    checks++;
    if (head_x == ox && head_y == oy && game_over == og) begin
      fails++;
      $display("FAIL step_timeout head=(%0d,%0d) no move in 16 cycles",
               head_x, head_y);
    end
  endtask

  task automatic test_reset();
    start = 0; dir = 2'd3; rand_x = 0; rand_y = 0;
    video_on = 0; pix_x = 0; pix_y = 0;
    rst_n = 0;
    cyc(2);
    checks++;
    if (head_x !== 5'd2 || head_y !== 5'd2) begin
      fails++;
      $display("FAIL reset_head got (%0d,%0d) want (2,2)", head_x, head_y);
    end
    checks++;
    if (length !== 6'd1 || score !== 16'h0) begin
      fails++;
      $display("FAIL reset_len_score got %0d/%h want 1/0000", length, score);
    end
    checks++;
    if (game_over !== 1'b0 || fruit_eaten !== 1'b0 || graph_rgb !== 3'b0) begin
      fails++;
      $display("FAIL reset_flags got go=%b fe=%b rgb=%b want 0,0,000",
               game_over, fruit_eaten, graph_rgb);
    end
    rst_n = 1;
    cyc(1);
  endtask

  task automatic test_move();
    int n;
    start = 1; dir = 2'd3;
    step_wait(n);
    checks++;
    if (head_x !== 5'd3 || head_y !== 5'd2) begin
      fails++;
      $display("FAIL move1 got (%0d,%0d) want (3,2)", head_x, head_y);
    end
    step_wait(n);
    checks++;
    if (head_x !== 5'd4 || head_y !== 5'd2 || n != 4) begin
      fails++;
      $display("FAIL move2 got (%0d,%0d) after %0d cycles want (4,2) after 4",
               head_x, head_y, n);
    end
    start = 0;
    dir = 2'd2;
    step_wait(n);
    checks++;
    if (head_x !== 5'd5 || head_y !== 5'd2) begin
      fails++;
      $display("FAIL reverse_ignored got (%0d,%0d) want (5,2)", head_x, head_y);
    end
    dir = 2'd0;
    step_wait(n);
    checks++;
    if (head_x !== 5'd5 || head_y !== 5'd1) begin
      fails++;
      $display("FAIL turn_up got (%0d,%0d) want (5,1)", head_x, head_y);
    end
    dir = 2'd2;
    step_wait(n);
    checks++;
    if (head_x !== 5'd4 || head_y !== 5'd1) begin
      fails++;
      $display("FAIL turn_left got (%0d,%0d) want (4,1)", head_x, head_y);
    end
    checks++;
    if (length !== 6'd1 || score !== 16'h0) begin
      fails++;
      $display("FAIL move_len got %0d/%h want 1/0000", length, score);
    end
  endtask

  task automatic test_eat();
    int n;
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    start = 1; dir = 2'd3; rand_x = 5'd6; rand_y = 5'd6;
    repeat (4) step_wait(n);
    start = 0;
    checks++;
    if (head_x !== 5'd6 || head_y !== 5'd2) begin
      fails++;
      $display("FAIL eat_path got (%0d,%0d) want (6,2)", head_x, head_y);
    end
    dir = 2'd1;
    repeat (4) step_wait(n);
    checks++;
    if (head_x !== 5'd6 || head_y !== 5'd6 || fruit_eaten !== 1'b1) begin
      fails++;
      $display("FAIL eat_pulse got (%0d,%0d) fe=%b want (6,6) fe=1",
               head_x, head_y, fruit_eaten);
    end
    checks++;
    if (length !== 6'd2 || score !== 16'h0001) begin
      fails++;
      $display("FAIL eat_grow got %0d/%h want 2/0001", length, score);
    end
    cyc(8);
    checks++;
    if (head_x !== 5'd6 || head_y !== 5'd6) begin
      fails++;
      $display("FAIL place_on_head got (%0d,%0d) want stall at (6,6)",
               head_x, head_y);
    end
    rand_x = 5'd6; rand_y = 5'd5;
    cyc(8);
    checks++;
    if (head_x !== 5'd6 || head_y !== 5'd6 || eat_cnt != 1) begin
      fails++;
      $display("FAIL place_on_body got (%0d,%0d) eats=%0d want (6,6) eats=1",
               head_x, head_y, eat_cnt);
    end
    for (int k = 7; k <= 9; k++) begin
      rand_y = 5'(k);
      step_wait(n);
      checks++;
      if (head_y !== 5'(k) || length !== 6'(k - 4)) begin
        fails++;
        $display("FAIL chain_eat got y=%0d len=%0d want y=%0d len=%0d",
                 head_y, length, k, k - 4);
      end
    end
    checks++;
    if (score !== 16'h0004) begin
      fails++;
      $display("FAIL chain_score got %h want 0004", score);
    end
    rand_x = 5'd30; rand_y = 5'd20;
    step_wait(n);
    checks++;
    if (head_x !== 5'd6 || head_y !== 5'd10 || length !== 6'd5 ||
        eat_cnt != 4) begin
      fails++;
      $display("FAIL after_place got (%0d,%0d) len=%0d eats=%0d want (6,10) 5 4",
               head_x, head_y, length, eat_cnt);
    end
  endtask

  task automatic test_collision();
    int n;
    dir = 2'd3;
    step_wait(n);
    dir = 2'd0;
    step_wait(n);
    checks++;
    if (head_x !== 5'd7 || head_y !== 5'd9 || game_over !== 1'b0) begin
      fails++;
      $display("FAIL pre_collide got (%0d,%0d) go=%b want (7,9) 0",
               head_x, head_y, game_over);
    end
    dir = 2'd2;
    step_wait(n);
    checks++;
    if (game_over !== 1'b1 || head_x !== 5'd7 || head_y !== 5'd9) begin
      fails++;
      $display("FAIL collide got go=%b (%0d,%0d) want 1 (7,9)",
               game_over, head_x, head_y);
    end
    cyc(8);
    checks++;
    if (head_x !== 5'd7 || head_y !== 5'd9 || score !== 16'h0004) begin
      fails++;
      $display("FAIL frozen got (%0d,%0d) %h want (7,9) 0004",
               head_x, head_y, score);
    end
  endtask

  task automatic test_render();
    int         vx [11] = '{177, 176, 152, 151, 157, 157, 157, 1, 602, 601, 100};
    int         vy [11] = '{227, 227, 227, 227, 32, 207, 182, 100, 100, 100, 477};
    logic [2:0] ve [11] = '{3'b011, 3'b010, 3'b010, 3'b000, 3'b100, 3'b010,
                            3'b000, 3'b111, 3'b111, 3'b000, 3'b111};
    video_on = 1;
    for (int i = 0; i < 11; i++) begin
      pix_x = 10'(vx[i]);
      pix_y = 10'(vy[i]);
      cyc(1);
      checks++;
      if (graph_rgb !== ve[i]) begin
        fails++;
        $display("FAIL render_%0d pix=(%0d,%0d) got %b want %b",
                 i, vx[i], vy[i], graph_rgb, ve[i]);
      end
    end
    pix_x = 10'd177; pix_y = 10'd227; video_on = 0;
    cyc(1);
    checks++;
    if (graph_rgb !== 3'b000) begin
      fails++;
      $display("FAIL render_blank got %b want 000", graph_rgb);
    end
  endtask

  task automatic test_restart();
    dir = 2'd3;
    start = 1;
    cyc(1);
    checks++;
    if (game_over !== 1'b0 || score !== 16'h0 || length !== 6'd1 ||
        head_x !== 5'd2 || head_y !== 5'd2) begin
      fails++;
      $display("FAIL restart got go=%b %h len=%0d (%0d,%0d) want 0 0000 1 (2,2)",
               game_over, score, length, head_x, head_y);
    end
    cyc(1);
    start = 0;
  endtask

  task automatic test_wrap();
    int n;
    step_wait(n);
    video_on = 1;
    pix_x = 10'd77; pix_y = 10'd52;
    cyc(1);
    checks++;
    if (graph_rgb !== 3'b011) begin
      fails++;
      $display("FAIL head_pix got %b want 011", graph_rgb);
    end
    pix_x = 10'd101;
    cyc(1);
    checks++;
    if (graph_rgb !== 3'b011) begin
      fails++;
      $display("FAIL head_pix_edge got %b want 011", graph_rgb);
    end
    pix_x = 10'd102;
    cyc(1);
    checks++;
    if (graph_rgb !== 3'b000) begin
      fails++;
      $display("FAIL next_cell_pix got %b want 000", graph_rgb);
    end
    for (int x = 4; x <= 23; x++) step_wait(n);
    checks++;
    if (head_x !== 5'd23 || head_y !== 5'd2) begin
      fails++;
      $display("FAIL edge got (%0d,%0d) want (23,2)", head_x, head_y);
    end
    step_wait(n);
    checks++;
`ifdef SNAKE_WALL_DEATH_EN
    if (game_over !== 1'b1 || head_x !== 5'd23) begin
      fails++;
      $display("FAIL wall got go=%b x=%0d want 1 23", game_over, head_x);
    end
`else
    if (game_over !== 1'b0 || head_x !== 5'd0 || head_y !== 5'd2) begin
      fails++;
      $display("FAIL wrap got go=%b (%0d,%0d) want 0 (0,2)",
               game_over, head_x, head_y);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_move();
    test_eat();
    test_collision();
    test_render();
    test_restart();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/snake_field_engine.md
Name: snake_field_engine

Overview:
- Parametrised grid-based snake game core with pixel renderer for the 640x480 VGA path.
- Holds a variable-length snake body of up to MAX_LEN cells and moves it one cell per game tick.
- Handles fruit eating and growth, self-collision and BCD scoring.
- Produces a registered 3-bit colour for each pixel supplied by the VGA sync block.

Parameters:
- GRID_W, 24, playfield width in cells
- GRID_H, 19, playfield height in cells
- CELL_PX, 25, cell edge in pixels
- ORG_X, 2, pixel x of cell column 0 left edge
- ORG_Y, 2, pixel y of cell row 0 top edge
- MAX_LEN, 32, maximum snake length in cells (power of two, 4..64)
- TICK_CYCLES, 8000000, clock cycles per game step
- CW, 5, cell coordinate width; must satisfy 2^CW >= max(GRID_W, GRID_H)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; begins a game from IDLE or GAME_OVER
- dir  in  2  requested direction: 0 up, 1 down, 2 left, 3 right
- rand_x  in  CW  free-running random column
- rand_y  in  CW  free-running random row
- video_on  in  1  active display region
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- graph_rgb  out  3  pixel colour, registered
- score  out  16  four BCD digits, digit 0 in [3:0]
- length  out  $clog2(MAX_LEN)+1  current snake length
- head_x  out  CW  head column
- head_y  out  CW  head row
- fruit_eaten  out  1  one-cycle pulse on eat
- game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (async, rst_n low) sets all outputs and state to zero, except head=(2,2) and length=1. Fruit is set to (6,6), state is IDLE, the tick counter is cleared and the latched direction is set to right.
- Body storage:
  - Circular buffer of MAX_LEN cells, with a head pointer and a length.
  - Segment k (k < length) sits at index head_ptr-k mod MAX_LEN.
- FSM states and transitions:
  - IDLE: snake drawn, no motion; start -> RUN, with the tick counter cleared.
  - RUN:
    - Tick counter counts 0..TICK_CYCLES-1.
    - At the terminal count it wraps to 0 and performs one STEP.
  - STEP (single cycle):
    - Compute next head from the latched direction.
    - Outside the grid, the head wraps: column -1 -> GRID_W-1, column GRID_W -> 0, and the same for rows.
    - If the next head equals any body segment 0..length-2 (the tail cell is vacating), go to GAME_OVER and do not move.
    - Otherwise advance head_ptr, write the next head and compare it with the fruit.
    - Fruit match: length += 1, saturating at MAX_LEN. At saturation the tail still moves, but score still increments.
    - Fruit match also pulses fruit_eaten, increments score as a BCD ripple (9999 -> 0000) and goes to PLACE.
    - No match: return to RUN.
  - PLACE:
    - Sample rand_x/rand_y each cycle, wrapping values >= GRID_W/GRID_H by subtraction.
    - Accept when the cell hits no segment: fruit := cell, return to RUN.
    - On a hit, retry next cycle. The tick counter keeps running; a tick arriving in PLACE is deferred until PLACE exits.
  - GAME_OVER: frozen, game_over=1; start -> reinitialise to reset values (score 0) and go to RUN.
- Direction latch:
  - Updated every cycle from dir in RUN.
  - A request for the exact reverse of the direction last used in a STEP is ignored (no 180° turns, even when length=1).
- Rendering, one-cycle latency (pixel-to-colour):
  - Pixel cell via parallel range compare: ORG + c*CELL_PX <= pix < ORG + (c+1)*CELL_PX.
  - Priority, highest first:
    1. !video_on -> 000.
    2. Border: pix_x < ORG_X, pix_x >= ORG_X+GRID_W*CELL_PX, or the y equivalents -> 111.
    3. Head -> 011.
    4. Body -> 010.
    5. Fruit -> 100.
    6. Otherwise 000.
- Start held high in RUN has no effect.
- Reset mid-STEP or mid-PLACE returns everything to reset values immediately.

Optional Feature:
- Macro: SNAKE_WALL_DEATH_EN.
- When defined, a next head outside the grid goes to GAME_OVER instead of wrapping.
- When undefined, wrap-around as above.
- Rendering is identical in both builds.

Decomposition:
- Package snake_pkg holds:
  - Direction encodings DIR_UP/DOWN/LEFT/RIGHT.
  - State enum IDLE/RUN/STEP/PLACE/GAME_OVER.
  - RGB constants for border, head, body, fruit and background.
  - A cell_t struct {x, y}.
- One sub-module, bcd_counter4: 4-digit BCD incrementer with enable and synchronous clear.

Test Plan:
- Reset, start, dir=right, TICK_CYCLES=4 -> head (2,2)->(3,2)->(4,2) at 4-cycle steps; length stays 1.
- Fruit forced at (3,2), one step right -> fruit_eaten pulses once, length=2, score=0x0001; new fruit never on (3,2)/(2,2) even when rand_x/rand_y first point there.
- Head at column 23 moving right -> next column 0 (macro undefined); with SNAKE_WALL_DEATH_EN, game_over=1 and head stays 23.
- dir=left while moving right -> ignored; then up, then left -> accepted.
- Length 5 looped into its own body -> game_over=1; start -> score 0, length 1, head (2,2).
- Pixel scan of pix=(2+3*25, 2+2*25) with head at (3,2), video_on=1 -> graph_rgb=011 one cycle later; video_on=0 -> 000.
